uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLOCK_FREQ, default 50_000_000, meaning system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115_200, meaning line bit rate in baud.
REQ-003 SHALL have parameter WIDTH, default 8, meaning data bits per frame.
REQ-004 SHALL have port clock  input  1  system clock.
REQ-005 SHALL have port resetn  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port rx  input  1  asynchronous serial line, idle high.
REQ-007 SHALL have port data  output  WIDTH  received word.
REQ-008 SHALL have port valid  output  1  data holds an unconsumed word.
REQ-009 SHALL have port ready  input  1  consumer accepts data when valid && ready.
REQ-010 SHALL have port framing_error  output  1  one-cycle pulse when the stop bit samples low.
REQ-011 SHALL have port overrun  output  1  one-cycle pulse when a word completes while valid is still high.

Function
REQ-012 SHALL define TPB = CLOCK_FREQ / BAUD_RATE (integer division) and reject TPB < 4 at elaboration.
REQ-013 SHALL pass rx through a 2-flop synchronizer; all decisions SHALL use the synchronized value rx_s.
REQ-014 SHALL implement states IDLE, START, DATA, STOP (plus PARITY when configured).
REQ-015 IDLE: on rx_s == 0, load tick counter with TPB/2 and go to START.
REQ-016 START: at counter expiry, if rx_s == 1 return to IDLE (glitch rejected, no output); otherwise reload TPB, clear bit index, go to DATA.
REQ-017 DATA: at each expiry, sample rx_s into bit[index] (LSB first) and reload TPB; after bit WIDTH-1 go to STOP (or PARITY).
REQ-018 STOP: at expiry, if rx_s == 1 deliver the word; if rx_s == 0 pulse framing_error, discard the word, and return to IDLE only after rx_s == 1 is seen.
REQ-019 Delivery SHALL occur on the cycle after the stop-bit sample: data updated, valid set to 1.
REQ-020 valid SHALL clear on the cycle after valid && ready; data SHALL stay stable while valid is high.
REQ-021 If a word completes while valid == 1 and ready == 0, it SHALL be dropped, data left unchanged, and overrun pulsed.
REQ-022 If a word completes in the same cycle as valid && ready, it SHALL be accepted: valid stays 1 with the new data, no overrun.
REQ-023 Stop-bit sampling SHALL return the block to IDLE at mid-stop, so back-to-back frames with one stop bit are received.
REQ-024 Counter widths SHALL be $clog2(TPB)+1 and $clog2(WIDTH)+1 bits; no counter SHALL wrap.

Reset
REQ-025 resetn low SHALL immediately set state to IDLE, valid, framing_error, and overrun to 0, data to 0, both synchronizer flops to 1, and counters to 0.
REQ-026 Reset mid-frame SHALL abort the frame; after release, the block SHALL wait in IDLE for the next falling edge, so a partial frame may surface as a framing error on the following byte only.

Configuration
REQ-027 Macro UART_RX_PARITY_EN defined: one even-parity bit follows the data bits; state PARITY samples it at expiry; a mismatch sets parity_error (output, 1 bit, one-cycle pulse at delivery time) and the word SHALL still be delivered.
REQ-028 Macro UART_RX_PARITY_EN undefined: no PARITY state and no parity_error port; the frame is start, WIDTH data bits, stop.

Structure
REQ-029 Package uart_pkg SHALL hold the rx state enum typedef and a function ticks_per_bit(clock_freq, baud_rate), shared with the transmitter.
REQ-030 Sub-module uart_rx_sync SHALL implement the 2-flop synchronizer with reset value 1; all other logic SHALL stay in uart_rx.

Verification (CLOCK_FREQ=50_000_000, BAUD_RATE=5_000_000, TPB=10, WIDTH=8)
REQ-031 Frame 0xA5 with ready=1 -> valid pulses with data=0xA5 about 95 cycles after the start edge; no error pulses.
REQ-032 Low glitch of 3 cycles on idle rx -> no valid, state back in IDLE, next frame 0x3C received correctly.
REQ-033 Frame 0x55 with stop bit forced low -> framing_error pulses once, valid stays 0; line restored high, then frame 0x0F -> data=0x0F.
REQ-034 ready=0, frames 0x11 then 0x22 back-to-back -> data=0x11 held, overrun pulses once at the second delivery; ready=1 -> valid clears.
REQ-035 resetn asserted at bit 4 of frame 0x77 -> outputs return to reset values immediately; next clean frame 0x81 -> data=0x81.
REQ-036 With UART_RX_PARITY_EN, frame 0x07 with parity bit 0 (wrong, since 0x07 has odd weight) -> data=0x07 delivered and parity_error pulses once.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state type and bit-timing helper (PARITY state only with UART_RX_PARITY_EN)
package uart_pkg;
   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
`ifdef UART_RX_PARITY_EN
      S_PARITY,
`endif
      S_STOP
   } rx_state_t;
   function automatic int ticks_per_bit(input int clock_freq, input int baud_rate);
      return clock_freq / baud_rate;
   endfunction
endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchronizer for the serial line, resets to the idle-high level
module uart_rx_sync (
   input  logic clock,
   input  logic resetn,
   input  logic d,
   output logic q
);
   logic meta;
   always_ff @(posedge clock or negedge resetn)
      if (!resetn) {q, meta} <= 2'b11;
      else {q, meta} <= {meta, d};
endmodule

// File: rtl/uart_rx.sv
// uart_rx: mid-bit sampling UART receiver with valid/ready output; UART_RX_PARITY_EN adds even parity
module uart_rx import uart_pkg::*; #(
   parameter int CLOCK_FREQ = 50_000_000,
   parameter int BAUD_RATE  = 115_200,
   parameter int WIDTH      = 8
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic             rx,
   output logic [WIDTH-1:0] data,
   output logic             valid,
   input  logic             ready,
   output logic             framing_error,
   output logic             overrun
`ifdef UART_RX_PARITY_EN
   ,
   output logic             parity_error
`endif
);
   localparam int TPB = ticks_per_bit(CLOCK_FREQ, BAUD_RATE);
   localparam int CW  = $clog2(TPB) + 1;
   localparam int IW  = $clog2(WIDTH) + 1;
   if (TPB < 4) begin : g_tpb_check
      $error("uart_rx: CLOCK_FREQ/BAUD_RATE must be at least 4");
   end
   rx_state_t        state;
   logic [CW-1:0]    cnt;
   logic [IW-1:0]    idx;
   logic [WIDTH-1:0] shreg;
   logic             rx_s;
   logic             tick;
`ifdef UART_RX_PARITY_EN
   logic             par;
`endif
   uart_rx_sync u_sync (.clock(clock), .resetn(resetn), .d(rx), .q(rx_s));
   assign tick = cnt == CW'(1);
   always_ff @(posedge clock or negedge resetn)
      if (!resetn) begin
         state         <= S_IDLE;
         cnt           <= '0;
         idx           <= '0;
         shreg         <= '0;
         data          <= '0;
         valid         <= 1'b0;
         framing_error <= 1'b0;
         overrun       <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par           <= 1'b0;
         parity_error  <= 1'b0;
`endif
      end else begin
         framing_error <= 1'b0;
         overrun       <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_error  <= 1'b0;
`endif
         if (valid && ready) valid <= 1'b0;
         if (cnt != '0) cnt <= cnt - 1'b1;
         case (state)
            S_IDLE: if (!rx_s) begin
               cnt   <= CW'(TPB / 2);
               state <= S_START;
            end
            S_START: if (tick) begin
               if (rx_s) state <= S_IDLE;
               else begin
                  cnt   <= CW'(TPB);
                  idx   <= '0;
                  state <= S_DATA;
               end
            end
            S_DATA: if (tick) begin
               shreg <= {rx_s, shreg[WIDTH-1:1]};
               cnt   <= CW'(TPB);
               idx   <= idx + 1'b1;
`ifdef UART_RX_PARITY_EN
               if (idx == IW'(WIDTH - 1)) state <= S_PARITY;
`else
               if (idx == IW'(WIDTH - 1)) state <= S_STOP;
`endif
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: if (tick) begin
               par   <= rx_s;
               cnt   <= CW'(TPB);
               state <= S_STOP;
            end
`endif
            // a low stop bit leaves cnt at 0 and parks here until the line returns high
            S_STOP: if (tick) begin
               if (rx_s) begin
                  state <= S_IDLE;
                  if (!valid || ready) begin
                     data  <= shreg;
                     valid <= 1'b1;
                  end else overrun <= 1'b1;
`ifdef UART_RX_PARITY_EN
                  parity_error <= ^shreg ^ par;
`endif
               end else framing_error <= 1'b1;
            end else if (cnt == '0 && rx_s) state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: table-driven frames plus hand sequences for glitch, overrun, reset and parity
module tb_uart_rx;
   import uart_pkg::*;
   logic clock = 1'b0;
   logic resetn = 1'b0;
   logic rx = 1'b1;
   logic ready = 1'b1;
   logic [7:0] data;
   logic valid, framing_error, overrun;
   int checks = 0, errors = 0;
   int hs_cnt = 0, fe_cnt = 0, ov_cnt = 0;
   logic [7:0] exp_q[$];
`ifdef UART_RX_PARITY_EN
   logic parity_error;
   int pe_cnt = 0;
`endif
   uart_rx #(.CLOCK_FREQ(50_000_000), .BAUD_RATE(5_000_000), .WIDTH(8)) dut (
      .clock(clock), .resetn(resetn), .rx(rx), .data(data), .valid(valid), .ready(ready),
`ifdef UART_RX_PARITY_EN
      .parity_error(parity_error),
`endif
      .framing_error(framing_error), .overrun(overrun)
   );
   always #5 clock = ~clock;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   always @(negedge clock) if (resetn) begin
      if (valid && ready) begin
         hs_cnt++;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_word: got %0h expected none", data);
         end else chk("rx_data", 32'(data), 32'(exp_q.pop_front()));
      end
      if (framing_error) fe_cnt++;
      if (overrun) ov_cnt++;
`ifdef UART_RX_PARITY_EN
      if (parity_error) pe_cnt++;
`endif
   end
   task automatic drive_bit(input logic b, input int cycles);
      @(posedge clock); #1 rx = b;
      repeat (cycles - 1) @(posedge clock);
   endtask
   task automatic send_frame(input logic [7:0] d, input logic stop, input logic par);
      drive_bit(1'b0, 10);
      for (int i = 0; i < 8; i++) drive_bit(d[i], 10);
`ifdef UART_RX_PARITY_EN
      drive_bit(par, 10);
`else
      if (par === 1'bx) rx = 1'b1;
`endif
      drive_bit(stop, 10);
      @(posedge clock); #1 rx = 1'b1;
   endtask
   task automatic idle(input int n);
      repeat (n) @(negedge clock);
   endtask
   typedef struct {
      logic [7:0] d;
      logic       stop;
      int         exp_hs;
      int         exp_fe;
   } vec_t;
   vec_t vecs[6];
   int hs0, fe0, ov0;
   initial begin
      vecs[0] = '{8'hA5, 1'b1, 1, 0};
      vecs[1] = '{8'h00, 1'b1, 1, 0};
      vecs[2] = '{8'hFF, 1'b1, 1, 0};
      vecs[3] = '{8'h55, 1'b0, 0, 1};
      vecs[4] = '{8'h0F, 1'b1, 1, 0};
      vecs[5] = '{8'hC3, 1'b1, 1, 0};
      idle(3);
      chk("rst_valid", 32'(valid), 0);
      chk("rst_data", 32'(data), 0);
      chk("rst_fe", 32'(framing_error), 0);
      chk("rst_ov", 32'(overrun), 0);
      @(posedge clock); #1 resetn = 1'b1;
      idle(5);
      foreach (vecs[k]) begin
         hs0 = hs_cnt; fe0 = fe_cnt; ov0 = ov_cnt;
         if (vecs[k].exp_hs != 0) exp_q.push_back(vecs[k].d);
         send_frame(vecs[k].d, vecs[k].stop, ^vecs[k].d);
         idle(30);
         chk($sformatf("vec%0d_valid", k), 32'(hs_cnt - hs0), 32'(vecs[k].exp_hs));
         chk($sformatf("vec%0d_fe", k), 32'(fe_cnt - fe0), 32'(vecs[k].exp_fe));
         chk($sformatf("vec%0d_ov", k), 32'(ov_cnt - ov0), 0);
      end
      hs0 = hs_cnt;
      drive_bit(1'b0, 3);
      @(posedge clock); #1 rx = 1'b1;
      idle(20);
      chk("glitch_valid", 32'(hs_cnt - hs0), 0);
      chk("glitch_idle", 32'(dut.state), 32'(S_IDLE));
      exp_q.push_back(8'h3C);
      send_frame(8'h3C, 1'b1, ^8'h3C);
      idle(30);
      chk("after_glitch_valid", 32'(hs_cnt - hs0), 1);
      @(posedge clock); #1 ready = 1'b0;
      hs0 = hs_cnt; ov0 = ov_cnt;
      exp_q.push_back(8'h11);
      send_frame(8'h11, 1'b1, ^8'h11);
      send_frame(8'h22, 1'b1, ^8'h22);
      idle(30);
      chk("ovr_valid", 32'(valid), 1);
      chk("ovr_data", 32'(data), 32'h11);
      chk("ovr_pulses", 32'(ov_cnt - ov0), 1);
      chk("ovr_no_hs", 32'(hs_cnt - hs0), 0);
      @(posedge clock); #1 ready = 1'b1;
      idle(3);
      chk("ovr_valid_clear", 32'(valid), 0);
      chk("ovr_hs", 32'(hs_cnt - hs0), 1);
      drive_bit(1'b0, 10);
      for (int i = 0; i < 4; i++) drive_bit(1'(8'h77 >> i), 10);
      drive_bit(1'b0, 5);
      @(posedge clock); #1 resetn = 1'b0; rx = 1'b1;
      #1;
      chk("mid_rst_valid", 32'(valid), 0);
      chk("mid_rst_data", 32'(data), 0);
      chk("mid_rst_state", 32'(dut.state), 32'(S_IDLE));
      idle(3);
      @(posedge clock); #1 resetn = 1'b1;
      idle(50);
      hs0 = hs_cnt; fe0 = fe_cnt;
      exp_q.push_back(8'h81);
      send_frame(8'h81, 1'b1, ^8'h81);
      idle(30);
      chk("post_rst_valid", 32'(hs_cnt - hs0), 1);
      chk("post_rst_fe", 32'(fe_cnt - fe0), 0);
`ifdef UART_RX_PARITY_EN
      chk("par_clean", 32'(pe_cnt), 0);
      hs0 = hs_cnt;
      exp_q.push_back(8'h07);
      send_frame(8'h07, 1'b1, 1'b0);
      idle(30);
      chk("par_valid", 32'(hs_cnt - hs0), 1);
      chk("par_err", 32'(pe_cnt), 1);
`endif
      chk("queue_empty", 32'(exp_q.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
